// File: rtl/button_debounce.sv
// button_debounce: per-channel two-flop synchroniser and stability-counter debouncer
// Each channel also produces registered one-cycle press and release strobes.
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_clean,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);
  localparam logic [WIDTH-1:0] IDLE = ACTIVE_LOW ? '1 : '0;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, lvl;
  assign lvl = ACTIVE_LOW ? ~sync2 : sync2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic clean, press, rel, diff, done;
    assign diff = lvl[i] != clean;
    assign done = diff && cnt == LAST;
    // Any cycle of agreement clears the count, so bounces restart the timer
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt   <= '0;
        clean <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        cnt   <= diff && !done ? cnt + 1'b1 : '0;
        clean <= done ? lvl[i] : clean;
        press <= done && lvl[i];
        rel   <= done && !lvl[i];
      end
    assign btn_clean[i]   = clean;
    assign btn_press[i]   = press;
    assign btn_release[i] = rel;
  end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed checks of the debouncer plus a randomised
// pass-through check of an unfiltered, active-high instance.
module tb_button_debounce;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] raw_a, clean_a, press_a, rel_a;
  logic [3:0] raw_b, clean_b, press_b, rel_b;
  int tests = 0, fails = 0;
  int press_cnt[4], rel_cnt[4];
  logic [3:0] h0, h1, h2, h3;

  always #5 clk = ~clk;

  button_debounce #(.WIDTH(4), .CNT_W(16), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .btn_raw(raw_a),
    .btn_clean(clean_a), .btn_press(press_a), .btn_release(rel_a)
  );

  button_debounce #(.WIDTH(4), .CNT_W(16), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .btn_raw(raw_b),
    .btn_clean(clean_b), .btn_press(press_b), .btn_release(rel_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each edge and tallying strobes
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        press_cnt[i] += int'(press_a[i]);
        rel_cnt[i]   += int'(rel_a[i]);
      end
      chk("press_and_release_exclusive", {28'd0, press_a & rel_a}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i] = 0;
    end
    raw_a = 4'hF;
    raw_b = 4'h0;
    reset_n = 1'b0;
    // 1: reset with buttons idle
    step(20);
    chk("reset_clean", {28'd0, clean_a}, 32'd0);
    chk("reset_press", {28'd0, press_a}, 32'd0);
    chk("reset_release", {28'd0, rel_a}, 32'd0);
    chk("reset_cnt0", 32'(dut_a.g_ch[0].cnt), 32'd0);
    reset_n = 1'b1;
    step(5);
    chk("idle_clean", {28'd0, clean_a}, 32'd0);
    chk("idle_no_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);
    // 2: press and release on channel 0
    raw_a[0] = 1'b0;
    step(9);
    chk("ch0_press_edge9", {28'd0, clean_a}, 32'd0);
    step(1);
    chk("ch0_press_clean", {28'd0, clean_a}, 32'd1);
    chk("ch0_press_strobe", {28'd0, press_a}, 32'd1);
    step(1);
    chk("ch0_press_1cycle", {28'd0, press_a}, 32'd0);
    chk("ch0_press_count", 32'(press_cnt[0]), 32'd1);
    raw_a[0] = 1'b1;
    step(9);
    chk("ch0_rel_edge9", {28'd0, clean_a}, 32'd1);
    step(1);
    chk("ch0_rel_clean", {28'd0, clean_a}, 32'd0);
    chk("ch0_rel_strobe", {28'd0, rel_a}, 32'd1);
    step(1);
    chk("ch0_rel_1cycle", {28'd0, rel_a}, 32'd0);
    chk("ch0_rel_count", 32'(rel_cnt[0]), 32'd1);
    // 3: bouncing channel 1
    raw_a[1] = 1'b0; step(3);
    raw_a[1] = 1'b1; step(3);
    raw_a[1] = 1'b0; step(3);
    raw_a[1] = 1'b1; step(3);
    raw_a[1] = 1'b0;
    step(9);
    chk("ch1_bounce_no_early", {28'd0, clean_a}, 32'd0);
    chk("ch1_bounce_no_strobe", 32'(press_cnt[1]), 32'd0);
    step(1);
    chk("ch1_settled_clean", {28'd0, clean_a}, 32'd2);
    chk("ch1_settled_strobe", {28'd0, press_a}, 32'd2);
    step(1);
    chk("ch1_one_press", 32'(press_cnt[1]), 32'd1);
    raw_a = 4'hF;
    step(12);
    chk("ch1_released", {28'd0, clean_a}, 32'd0);
    // 4: glitch one cycle short of the threshold, then exactly at it
    raw_a[2] = 1'b0; step(7);
    raw_a[2] = 1'b1; step(12);
    chk("ch2_glitch7_clean", {28'd0, clean_a}, 32'd0);
    chk("ch2_glitch7_strobe", 32'(press_cnt[2]), 32'd0);
    raw_a[2] = 1'b0; step(8);
    raw_a[2] = 1'b1; step(1);
    chk("ch2_pulse8_edge9", {28'd0, clean_a}, 32'd0);
    step(1);
    chk("ch2_pulse8_clean", {28'd0, clean_a}, 32'd4);
    chk("ch2_pulse8_strobe", {28'd0, press_a}, 32'd4);
    step(12);
    chk("ch2_pulse8_released", {28'd0, clean_a}, 32'd0);
    chk("ch2_rel_count", 32'(rel_cnt[2]), 32'd1);
    // 5: simultaneous presses, then reset in the middle of a count
    raw_a = 4'b0110;
    step(9);
    chk("ch03_edge9", {28'd0, clean_a}, 32'd0);
    step(1);
    chk("ch03_clean", {28'd0, clean_a}, 32'h9);
    chk("ch03_strobes", {28'd0, press_a}, 32'h9);
    raw_a = 4'hF;
    step(12);
    chk("ch03_released", {28'd0, clean_a}, 32'd0);
    raw_a[0] = 1'b0;
    step(7);
    chk("ch0_mid_count", 32'(dut_a.g_ch[0].cnt), 32'd5);
    reset_n = 1'b0;
    step(2);
    chk("ch0_reset_clean", {28'd0, clean_a}, 32'd0);
    chk("ch0_reset_cnt", 32'(dut_a.g_ch[0].cnt), 32'd0);
    reset_n = 1'b1;
    step(9);
    chk("ch0_after_reset_edge9", {28'd0, clean_a}, 32'd0);
    chk("ch0_reset_no_strobe", 32'(press_cnt[0]), 32'd2);
    step(1);
    chk("ch0_after_reset_clean", {28'd0, clean_a}, 32'd1);
    chk("ch0_after_reset_strobe", {28'd0, press_a}, 32'd1);
    // 6: unfiltered active-high instance tracks its pins three edges later
    h0 = 4'd0; h1 = 4'd0; h2 = 4'd0; h3 = 4'd0;
    for (int n = 0; n < 10000; n++) begin
      h3 = h2; h2 = h1; h1 = h0;
      h0 = 4'($urandom);
      raw_b = h0;
      step(1);
      chk("b_clean", {28'd0, clean_b}, {28'd0, h2});
      chk("b_press", {28'd0, press_b}, {28'd0, h2 & ~h3});
      chk("b_release", {28'd0, rel_b}, {28'd0, ~h2 & h3});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
